// File: rtl/trig_capture_buf.sv
// Triggered capture buffer: records pre/post-trigger samples into a
// circular RAM, then streams the window out oldest-first over valid/ready.
module trig_capture_buf #(
    parameter int DATA_WIDTH = 25,
    parameter int LEN        = 512,
    parameter int PRE_TRIG   = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic [DATA_WIDTH-1:0] di,
    input  logic                  arm,
    input  logic                  trig,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy
);
    localparam int AW = $clog2(LEN);
    localparam int CW = $clog2(LEN + 1);
    localparam logic [CW-1:0] PRE_C  = CW'(PRE_TRIG);
    localparam logic [CW-1:0] POST_C = CW'(LEN - PRE_TRIG);
    localparam logic [CW-1:0] LEN_C  = CW'(LEN);
    localparam logic [AW-1:0] PRE_A  = AW'(PRE_TRIG);

    typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, READ} state_e;

    state_e                state_q, state_d;
    logic [AW-1:0]         wr_addr_q, wr_addr_d;
    logic [AW-1:0]         rd_addr_q, rd_addr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q, m_last_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [CW-1:0]         cnt_inc;
    logic                  wr_en;
    logic                  rd_en;
    logic                  adv;

    logic [DATA_WIDTH-1:0] mem [LEN];

    assign cnt_inc = cnt_q + CW'(1);
    // The RAM output register is the output stage; it reloads only when
    // the current beat is consumed or the stage is empty.
    assign adv     = !m_valid_q || m_ready;

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        cnt_d     = cnt_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arm) begin
                    cnt_d   = '0;
                    state_d = (PRE_TRIG == 0) ? ARMED : FILL;
                end
            end
            FILL: begin
                if (ce) begin
                    wr_en     = 1'b1;
                    wr_addr_d = wr_addr_q + AW'(1);
                    cnt_d     = cnt_inc;
                    if (cnt_inc == PRE_C) state_d = ARMED;
                end
            end
            ARMED: begin
                if (ce) begin
                    wr_en     = 1'b1;
                    wr_addr_d = wr_addr_q + AW'(1);
                    if (trig) begin
                        rd_addr_d = wr_addr_q - PRE_A;
                        if (POST_C == CW'(1)) begin
                            cnt_d   = '0;
                            state_d = READ;
                        end else begin
                            cnt_d   = CW'(1);
                            state_d = POST;
                        end
                    end
                end
            end
            POST: begin
                if (ce) begin
                    wr_en     = 1'b1;
                    wr_addr_d = wr_addr_q + AW'(1);
                    cnt_d     = cnt_inc;
                    if (cnt_inc == POST_C) begin
                        cnt_d   = '0;
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (adv) begin
                    if (cnt_q != LEN_C) begin
                        rd_en     = 1'b1;
                        rd_addr_d = rd_addr_q + AW'(1);
                        cnt_d     = cnt_inc;
                        m_valid_d = 1'b1;
                        m_last_d  = (cnt_q == LEN_C - CW'(1));
                    end else begin
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            cnt_q     <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            cnt_q     <= cnt_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr_q] <= di;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) rd_data_q <= '0;
        else if (rd_en) rd_data_q <= mem[rd_addr_q];
    end

    assign m_data  = rd_data_q;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign busy    = (state_q != IDLE);
endmodule

// File: tb/tb_trig_capture_buf.sv
// Bench for trig_capture_buf: directed captures with literal pins plus
// random traffic, all checked against a sample-history model.
module tb_trig_capture_buf;
    localparam int DW  = 25;
    localparam int LEN = 16;
    localparam int PRE = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ce = 1'b0;
    logic          arm = 1'b0;
    logic          trig = 1'b0;
    logic          m_ready = 1'b1;
    logic [DW-1:0] di = '0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          busy;

    always #5 clk = ~clk;

    trig_capture_buf #(
        .DATA_WIDTH(DW),
        .LEN(LEN),
        .PRE_TRIG(PRE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ce(ce),
        .di(di),
        .arm(arm),
        .trig(trig),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_last(m_last),
        .busy(busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: 0 idle, 1 capturing, 2 reading out
    int            phase = 0;
    bit            busy_m = 1'b0;
    bit            trig_seen = 1'b0;
    int            post_left = 0;
    logic [DW-1:0] hist[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got[$];
    bit            rst_chk = 1'b0;
    bit            prev_hold = 1'b0;
    bit            prev_rdy = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    bit            started = 1'b0;
    int            wt = 0;

    always @(negedge clk) begin
        int ph;
        logic [DW-1:0] e;
        ph = phase;
        if (rst_chk) begin
            chk("rst_valid", m_valid, 0);
            chk("rst_last", m_last, 0);
            chk("rst_data", m_data, 0);
            chk("rst_busy", busy, 0);
        end else begin
            chk("busy", busy, busy_m);
            if (ph != 2) chk("valid_outside_read", m_valid, 0);
            if (prev_hold) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, prev_data);
                chk("hold_last", m_last, prev_last);
            end
            if (ph == 2) begin
                if (m_valid) started = 1'b1;
                else if (!started) begin
                    wt++;
                    chk("first_valid_wait", wt <= 2, 1);
                end else if (prev_rdy && exp_q.size() > 0)
                    chk("readout_gap", m_valid, 1);
            end
        end
        rst_chk = 1'b0;
        if (!rst_n) begin
            phase = 0;
            busy_m = 1'b0;
            hist.delete();
            exp_q.delete();
            rst_chk = 1'b1;
            prev_hold = 1'b0;
            prev_rdy = 1'b0;
        end else begin
            if (ph == 2 && m_valid && m_ready) begin
                e = exp_q.pop_front();
                chk("beat_data", m_data, e);
                chk("beat_last", m_last, exp_q.size() == 0);
                got.push_back(m_data);
                if (exp_q.size() == 0) begin
                    phase = 0;
                    busy_m = 1'b0;
                end
            end
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
            prev_last = m_last;
            prev_rdy = m_ready;
            if (ph == 0) begin
                if (arm) begin
                    phase = 1;
                    busy_m = 1'b1;
                    hist.delete();
                    trig_seen = 1'b0;
                end
            end else if (ph == 1 && ce) begin
                if (!trig_seen && trig && hist.size() >= PRE) begin
                    trig_seen = 1'b1;
                    post_left = LEN - PRE;
                end
                hist.push_back(di);
                if (trig_seen) begin
                    post_left--;
                    if (post_left == 0) begin
                        exp_q.delete();
                        for (int i = hist.size() - LEN; i < hist.size(); i++)
                            exp_q.push_back(hist[i]);
                        phase = 2;
                        started = 1'b0;
                        wt = 0;
                    end
                end
            end
        end
    end

    task automatic capture(input int trig_a, input int trig_b, input int ce_per,
                           input int trig_ce0, input bit stall,
                           input int rst_beat, input int first_exp);
        int n = 0;
        int k = 0;
        int cyc = 0;
        int hold = 0;
        bit stalled = 1'b0;
        bit did_rst = 1'b0;
        got.delete();
        @(posedge clk); #1;
        arm = 1'b1;
        trig = 1'b1;
        ce = 1'b1;
        di = '1;
        @(posedge clk); #1;
        arm = 1'b0;
        while (cyc < 3000) begin
            ce = (k % ce_per) == 0;
            k++;
            di = DW'(n);
            trig = (ce && (n == trig_a || n == trig_b)) || (!ce && n == trig_ce0);
            if (ce) n++;
            if (stall) begin
                if (got.size() == 7 && !stalled) begin
                    hold = 5;
                    stalled = 1'b1;
                end
                m_ready = (hold > 0) ? 1'b0 : 1'((cyc % 2) == 0);
                if (hold > 0) hold--;
            end else m_ready = 1'b1;
            if (rst_beat >= 0 && got.size() == rst_beat && !did_rst) begin
                rst_n = 1'b0;
                did_rst = 1'b1;
            end else rst_n = 1'b1;
            cyc++;
            @(posedge clk); #1;
            if (!busy_m) break;
        end
        rst_n = 1'b1;
        trig = 1'b0;
        m_ready = 1'b1;
        chk("capture_timeout", cyc < 3000, 1);
        chk("busy_after", busy, 0);
        if (rst_beat < 0) begin
            chk("n_beats", got.size(), LEN);
            if (got.size() >= LEN) begin
                chk("first_beat", got[0], first_exp);
                chk("last_beat", got[LEN-1], first_exp + LEN - 1);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_busy", busy, 0);
        chk("reset_valid", m_valid, 0);
        capture(10, -1, 1, -1, 1'b0, -1, 6);
        capture(2, 5, 1, -1, 1'b0, -1, 1);
        capture(40, -1, 1, -1, 1'b0, -1, 36);
        capture(10, -1, 1, -1, 1'b1, -1, 6);
        capture(10, -1, 3, 7, 1'b0, -1, 6);
        capture(10, -1, 1, -1, 1'b0, 5, 0);
        capture(10, -1, 1, -1, 1'b0, -1, 6);
        repeat (4000) begin
            @(posedge clk); #1;
            rst_n = $urandom_range(0, 499) != 0;
            arm = ($urandom % 25) == 0;
            trig = ($urandom % 6) == 0;
            ce = ($urandom % 4) != 0;
            di = DW'($urandom);
            m_ready = ($urandom % 4) != 0;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        arm = 1'b0;
        trig = 1'b1;
        ce = 1'b1;
        m_ready = 1'b1;
        repeat (LEN * 4 + 20) @(posedge clk);
        #1;
        trig = 1'b0;
        chk("final_idle", busy, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
